// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 fetch constants: icodes, status codes, fetch states
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    F_B0,
    F_B1,
    F_C,
    OUT,
    WAIT_PC,
    HALTED
  } fetch_state_t;

  // Instruction length in bytes: opcode byte, optional register byte, optional 8-byte constant.
  function automatic logic [3:0] instr_len(input logic need_regids, input logic need_valc);
    instr_len = 4'd1 + {3'd0, need_regids} + (need_valc ? 4'd8 : 4'd0);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - fetch-stage bundle: instruction memory port, decode output, next-PC input
interface pc_fetch_if;
  import y86_pkg::*;

  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_err;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [63:0] valc;
  logic [63:0] valp;
  logic [2:0]  stat;

  logic        pc_load;
  logic [63:0] pc_next;
  logic [63:0] pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata, mem_err,
    output out_valid, icode, ifun, ra, rb, valc, valp, stat,
    input  out_ready,
    input  pc_load, pc_next,
    output pc
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata, mem_err,
    input  out_valid, icode, ifun, ra, rb, valc, valp, stat,
    output out_ready,
    output pc_load, pc_next,
    input  pc
  );

endinterface

// File: rtl/pc_fetch_instr_len_decode.sv
// rtl/pc_fetch_instr_len_decode.sv - icode to instruction-shape decode
module instr_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       need_regids,
  output logic       need_valc,
  output logic       instr_valid
);

  always_comb begin
    need_regids = 1'b0;
    need_valc   = 1'b0;
    instr_valid = 1'b1;
    case (icode)
      I_HALT, I_NOP, I_RET: ;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
      I_JXX, I_CALL: need_valc = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      default: instr_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - Y86-64 fetch: byte-serial instruction read, field assembly, next-PC handoff
module pc_fetch
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_fetch_if.master    bus
);

  fetch_state_t state, state_n;
  logic [63:0]  pc_q;
  logic [2:0]   cnt;
  logic         req_q;
  logic [3:0]   icode_q, ifun_q, ra_q, rb_q;
  logic [63:0]  valc_q, valp_q;
  logic [2:0]   stat_q;

  logic         xfer;
  logic         fetch_n;
  logic [3:0]   dec_icode;
  logic         need_regids, need_valc, instr_valid;
  logic [3:0]   offset;

  // The opcode byte is decoded straight off the bus; later bytes use the captured icode.
  assign dec_icode = (state == F_B0) ? bus.mem_rdata[7:4] : icode_q;

  instr_len_decode u_dec (
    .icode       (dec_icode),
    .need_regids (need_regids),
    .need_valc   (need_valc),
    .instr_valid (instr_valid)
  );

  assign xfer = req_q && bus.mem_ack;

  always_comb begin
    state_n = state;
    case (state)
      F_B0: if (xfer) begin
        if (bus.mem_err || !instr_valid) state_n = OUT;
        else if (need_regids)            state_n = F_B1;
        else if (need_valc)              state_n = F_C;
        else                             state_n = OUT;
      end
      F_B1: if (xfer) begin
        if (bus.mem_err)    state_n = OUT;
        else if (need_valc) state_n = F_C;
        else                state_n = OUT;
      end
      F_C: if (xfer) begin
        if (bus.mem_err || cnt == 3'd7) state_n = OUT;
      end
      OUT: if (bus.out_ready) begin
        state_n = (stat_q == S_AOK) ? WAIT_PC : HALTED;
      end
      WAIT_PC: if (bus.pc_load) state_n = F_B0;
      default: state_n = state;
    endcase
  end

  assign fetch_n = (state_n == F_B0) || (state_n == F_B1) || (state_n == F_C);

  always_comb begin
    offset = 4'd0;
    case (state)
      F_B1:    offset = 4'd1;
      F_C:     offset = (need_regids ? 4'd2 : 4'd1) + {1'b0, cnt};
      default: offset = 4'd0;
    endcase
  end

  // Request is registered so it is low throughout reset and rises one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= F_B0;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      cnt     <= 3'd0;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= REG_NONE;
      rb_q    <= REG_NONE;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      stat_q  <= S_AOK;
    end else begin
      state <= state_n;
      req_q <= fetch_n;
      case (state)
        F_B0: if (xfer) begin
          cnt <= 3'd0;
          if (bus.mem_err) begin
            stat_q <= S_ADR;
          end else begin
            icode_q <= bus.mem_rdata[7:4];
            ifun_q  <= bus.mem_rdata[3:0];
            if (!instr_valid) begin
              stat_q <= S_INS;
            end else begin
              valp_q <= pc_q + 64'(instr_len(need_regids, need_valc));
              if (bus.mem_rdata[7:4] == I_HALT) stat_q <= S_HLT;
            end
          end
        end
        F_B1: if (xfer) begin
          if (bus.mem_err) begin
            stat_q <= S_ADR;
          end else begin
            ra_q <= bus.mem_rdata[7:4];
            rb_q <= bus.mem_rdata[3:0];
          end
        end
        F_C: if (xfer) begin
          if (bus.mem_err) begin
            stat_q <= S_ADR;
          end else begin
            valc_q[{cnt, 3'b000} +: 8] <= bus.mem_rdata;
            cnt <= cnt + 3'd1;
          end
        end
        WAIT_PC: if (bus.pc_load) begin
          pc_q    <= bus.pc_next;
          icode_q <= 4'h0;
          ifun_q  <= 4'h0;
          ra_q    <= REG_NONE;
          rb_q    <= REG_NONE;
          valc_q  <= 64'd0;
          valp_q  <= 64'd0;
          stat_q  <= S_AOK;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = pc_q + {60'd0, offset};
  assign bus.out_valid = (state == OUT);
  assign bus.icode     = icode_q;
  assign bus.ifun      = ifun_q;
  assign bus.ra        = ra_q;
  assign bus.rb        = rb_q;
  assign bus.valc      = valc_q;
  assign bus.valp      = valp_q;
  assign bus.stat      = stat_q;
  assign bus.pc        = pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - randomized scoreboard bench for pc_fetch
module tb_pc_fetch;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_if bus();
  pc_fetch #(.RESET_PC(64'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [7:0]  mem [logic [63:0]];
  logic        err_en = 1'b0;
  logic [63:0] err_addr = 64'd0;
  int          fixed_delay = 0;
  int          ready_mode = 1;
  bit          halted = 1'b1;
  exp_t        exp_q [$];
  logic [63:0] addr_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic miss(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic int len_of(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  // Walks the bytes an instruction occupies; stops at the first byte that errors.
  function automatic exp_t ref_model(input logic [63:0] pc, input logic [7:0] b [10],
                                     input int err_k, output int nbytes);
    exp_t e;
    int   len;
    e = '{icode: 4'h0, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0, stat: 3'd1};
    nbytes = 1;
    if (err_k == 0) begin e.stat = 3'd3; return e; end
    e.icode = b[0][7:4];
    e.ifun  = b[0][3:0];
    len = len_of(e.icode);
    if (len == 0) begin e.stat = 3'd4; return e; end
    e.valp = pc + 64'(len);
    if (e.icode == 4'h0) e.stat = 3'd2;
    for (int k = 1; k < len; k++) begin
      nbytes = k + 1;
      if (k == err_k) begin e.stat = 3'd3; return e; end
      if ((len == 2 || len == 10) && k == 1) begin
        e.ra = b[1][7:4];
        e.rb = b[1][3:0];
      end else begin
        e.valc[8*(k-(len-8)) +: 8] = b[k];
      end
    end
    return e;
  endfunction

  // Instruction memory: optional wait states, stray acks while idle, address checks.
  initial begin : responder
    bit          busy = 1'b0;
    int          wait_left = 0;
    logic [63:0] held = 64'd0;
    logic [63:0] a;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    bus.mem_err = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_err = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (!bus.mem_req) begin
        busy = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = 8'($urandom);
          bus.mem_err = 1'($urandom_range(0, 1));
        end
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
          held = bus.mem_addr;
        end else begin
          chk("addr_stable", bus.mem_addr, held);
        end
        if (wait_left == 0) begin
          busy = 1'b0;
          a = bus.mem_addr;
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mem.exists(a) ? mem[a] : 8'h00;
          bus.mem_err = err_en && (a == err_addr);
          if (addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_req: request at %h when none expected", a);
          end else begin
            chk("mem_addr", a, addr_q.pop_front());
          end
        end else begin
          wait_left--;
        end
      end
    end
  end

  initial begin : ready_drv
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'($urandom_range(0, 1));
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          miss("unexpected_output");
        end else begin
          e = exp_q.pop_front();
          chk("icode", 64'(bus.icode), 64'(e.icode));
          chk("ifun",  64'(bus.ifun),  64'(e.ifun));
          chk("ra",    64'(bus.ra),    64'(e.ra));
          chk("rb",    64'(bus.rb),    64'(e.rb));
          chk("valc",  bus.valc,       e.valc);
          chk("valp",  bus.valp,       e.valp);
          chk("stat",  64'(bus.stat),  64'(e.stat));
        end
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mem_req",   64'(bus.mem_req),   64'd0);
    chk("rst_pc",        bus.pc,             64'd0);
    chk("rst_icode",     64'({bus.icode, bus.ifun}), 64'h00);
    chk("rst_regs",      64'({bus.ra, bus.rb}), 64'hFF);
    chk("rst_valc_valp", bus.valc | bus.valp, 64'd0);
    chk("rst_stat",      64'(bus.stat), 64'd1);
  endtask

  task automatic run_episode(input logic [63:0] pc, input logic [7:0] b [10], input int err_k,
                             input int delay, input int hold);
    exp_t e;
    int   nb, cyc, t;
    bit   from_reset;
    from_reset = halted;
    for (int k = 0; k < 10; k++) mem[pc + 64'(k)] = b[k];
    err_en = (err_k >= 0);
    err_addr = pc + 64'(err_k);
    fixed_delay = delay;
    e = ref_model(pc, b, err_k, nb);
    exp_q.push_back(e);
    for (int k = 0; k < nb; k++) addr_q.push_back(pc + 64'(k));
    if (from_reset) begin
      rst_n = 1'b0;
      #1;
      check_reset_state();
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      bus.pc_next = pc;
      bus.pc_load = 1'b1;
    end
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      @(negedge clk);
      bus.pc_load = 1'b0;
      cyc++;
    end
    if (!bus.out_valid) miss("out_valid_timeout");
    else if (delay == 0) chk("latency", 64'(cyc), 64'(nb + 1));
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      if (exp_q.size() != 0) chk("hold_valc", bus.valc, exp_q[0].valc);
      @(negedge clk);
    end
    if (hold > 0) ready_mode = 1;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      miss("accept_timeout");
      exp_q.delete();
    end
    @(negedge clk);
    chk("req_count", 64'(addr_q.size()), 64'd0);
    addr_q.delete();
    chk("pc", bus.pc, pc);
    halted = (e.stat != 3'd1);
    if (halted) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("halt_idle", 64'({bus.mem_req, bus.out_valid}), 64'd0);
      end
      bus.pc_next = 64'h40;
      bus.pc_load = 1'b1;
      @(negedge clk);
      bus.pc_load = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("halt_req", 64'(bus.mem_req), 64'd0);
      end
      chk("halt_pc", bus.pc, pc);
      chk("halt_stat", 64'(bus.stat), 64'(e.stat));
    end
  endtask

  task automatic abort_in_valc(input logic [63:0] pc, input logic [7:0] b [10]);
    int t;
    for (int k = 0; k < 10; k++) mem[pc + 64'(k)] = b[k];
    err_en = 1'b0;
    fixed_delay = 2;
    for (int k = 0; k < 10; k++) addr_q.push_back(pc + 64'(k));
    bus.pc_next = pc;
    bus.pc_load = 1'b1;
    @(negedge clk);
    bus.pc_load = 1'b0;
    t = 0;
    while (!(bus.mem_req && bus.mem_addr == pc + 64'd3) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) miss("abort_wait_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_mem_req", 64'(bus.mem_req), 64'd0);
    chk("abort_pc", bus.pc, 64'd0);
    addr_q.delete();
    exp_q.delete();
    halted = 1'b1;
    @(negedge clk);
  endtask

  initial begin : stim
    logic [7:0]  b [10];
    logic [63:0] pc;
    int          err_k, dly;
    bus.pc_load = 1'b0;
    bus.pc_next = 64'd0;
    @(negedge clk);

    b = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_episode(64'h0, b, -1, 0, 0);
    b = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    run_episode(64'h100, b, -1, 0, 0);
    b = '{8'h70, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    run_episode(64'hFFFF_FFFF_FFFF_FFFC, b, -1, 2, 0);
    b = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_episode(64'h200, b, -1, 0, 0);
    b = '{8'h40, 8'h12, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};
    run_episode(64'h0, b, 3, -1, 0);
    b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_episode(64'h0, b, -1, 0, 0);
    b = '{8'h60, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ready_mode = 2;
    run_episode(64'h0, b, -1, 0, 5);
    b = '{8'hA0, 8'h4F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_episode(64'h40, b, -1, 0, 0);
    b = '{8'h50, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    abort_in_valc(64'h300, b);

    ready_mode = 0;
    for (int n = 0; n < 60; n++) begin
      if (halted) pc = 64'h0;
      else if ($urandom_range(0, 3) == 0) pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else pc = {$urandom, $urandom};
      for (int k = 0; k < 10; k++) b[k] = 8'($urandom);
      if ($urandom_range(0, 3) != 0) b[0][7:4] = 4'($urandom_range(1, 11));
      err_k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
      dly = ($urandom_range(0, 1) == 0) ? 0 : -1;
      run_episode(pc, b, err_k, dly, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
